// File: rtl/decode_regfile_issue.sv
// Decode/issue stage: accepts instructions from fetch, reads a 32x32 register file,
// issues to the ALU, waits for the result, writes back to rd and returns the next pc.
module decode_regfile_issue #(
  parameter int WB_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instruction,
  input  logic [31:0] in_pc,
  output logic        alu_valid,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_pc,
  output logic [31:0] alu_rs1_data,
  output logic [31:0] alu_rs2_data,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_next_pc,
  input  logic        alu_result_valid,
  input  logic        alu_is_jump,
  output logic        pc_update_valid,
  output logic [31:0] pc_update,
  output logic        illegal_instr,
  output logic        alu_timeout,
  output logic [15:0] jump_count,
  input  logic        dbg_we,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata
);

  // Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and in_valid is not required to stay high afterwards.
  localparam int CW = $clog2(WB_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ILLEGAL} state_t;

  state_t        state, state_next;
  logic [31:0]   rf [32];
  logic [31:0]   instr_q, pc_q, rs1_q, rs2_q;
  logic [CW-1:0] wait_cnt;
  logic [15:0]   jump_cnt;
  logic          legal;
  logic [4:0]    rs1_idx, rs2_idx, rd_idx;
  logic [31:0]   rs1_rd, rs2_rd, pc_plus4;

  assign rs1_idx  = instr_q[19:15];
  assign rs2_idx  = instr_q[24:20];
  assign rd_idx   = instr_q[11:7];
  assign rs1_rd   = (rs1_idx == 5'd0) ? 32'd0 : rf[rs1_idx];
  assign rs2_rd   = (rs2_idx == 5'd0) ? 32'd0 : rf[rs2_idx];
  assign pc_plus4 = pc_q + 32'd4;

  assign alu_instruction = instr_q;
  assign alu_pc          = pc_q;
  // Operands come straight from the regfile while issuing, then stay frozen.
  assign alu_rs1_data    = (state == S_ISSUE) ? rs1_rd : rs1_q;
  assign alu_rs2_data    = (state == S_ISSUE) ? rs2_rd : rs2_q;
  assign jump_count      = jump_cnt;
  assign dbg_rdata       = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

  always_comb begin
    legal = 1'b0;
    if (in_instruction[6:0] == 7'h6F) begin
      legal = 1'b1;
    end else if (in_instruction[6:0] == 7'h33) begin
      if (in_instruction[31:25] == 7'h00)
        legal = in_instruction[14:12] inside {3'b000, 3'b100, 3'b110, 3'b111};
      else if (in_instruction[31:25] == 7'h20)
        legal = (in_instruction[14:12] == 3'b000);
    end
  end

  always_comb begin
    state_next      = state;
    in_ready        = 1'b0;
    alu_valid       = 1'b0;
    pc_update_valid = 1'b0;
    pc_update       = 32'd0;
    illegal_instr   = 1'b0;
    alu_timeout     = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = legal ? S_ISSUE : S_ILLEGAL;
      end
      S_ISSUE: begin
        alu_valid  = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (alu_result_valid) begin
          pc_update_valid = 1'b1;
          pc_update       = alu_next_pc;
          state_next      = S_IDLE;
        end else if (wait_cnt == CW'(WB_TIMEOUT)) begin
          alu_timeout     = 1'b1;
          pc_update_valid = 1'b1;
          pc_update       = pc_plus4;
          state_next      = S_IDLE;
        end
      end
      S_ILLEGAL: begin
        illegal_instr   = 1'b1;
        pc_update_valid = 1'b1;
        pc_update       = pc_plus4;
        state_next      = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // A cycle that is being reset must not announce a retirement.
    if (!resetn) begin
      alu_valid       = 1'b0;
      pc_update_valid = 1'b0;
      illegal_instr   = 1'b0;
      alu_timeout     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      instr_q  <= 32'd0;
      pc_q     <= 32'd0;
      rs1_q    <= 32'd0;
      rs2_q    <= 32'd0;
      wait_cnt <= '0;
      jump_cnt <= 16'd0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && in_valid) begin
        instr_q <= in_instruction;
        pc_q    <= in_pc;
      end
      if (state == S_ISSUE) begin
        rs1_q    <= rs1_rd;
        rs2_q    <= rs2_rd;
        wait_cnt <= '0;
      end else if (state == S_WAIT && !alu_result_valid) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == S_IDLE && dbg_we && dbg_addr != 5'd0)
        rf[dbg_addr] <= dbg_wdata;
      if (state == S_WAIT && alu_result_valid) begin
        if (rd_idx != 5'd0) rf[rd_idx] <= alu_result;
        if (alu_is_jump) jump_cnt <= jump_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_decode_regfile_issue.sv
// Bench for decode_regfile_issue: the bench plays fetch and a 1..N cycle ALU, and
// predicts register file, pc updates and jump count from the instruction semantics.
module tb_decode_regfile_issue;

  localparam int WB_TIMEOUT = 16;

  logic        clk, resetn;
  logic        in_valid, in_ready;
  logic [31:0] in_instruction, in_pc;
  logic        alu_valid;
  logic [31:0] alu_instruction, alu_pc, alu_rs1_data, alu_rs2_data;
  logic [31:0] alu_result, alu_next_pc;
  logic        alu_result_valid, alu_is_jump;
  logic        pc_update_valid;
  logic [31:0] pc_update;
  logic        illegal_instr, alu_timeout;
  logic [15:0] jump_count;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;

  decode_regfile_issue #(.WB_TIMEOUT(WB_TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc),
    .alu_valid(alu_valid), .alu_instruction(alu_instruction), .alu_pc(alu_pc),
    .alu_rs1_data(alu_rs1_data), .alu_rs2_data(alu_rs2_data),
    .alu_result(alu_result), .alu_next_pc(alu_next_pc),
    .alu_result_valid(alu_result_valid), .alu_is_jump(alu_is_jump),
    .pc_update_valid(pc_update_valid), .pc_update(pc_update),
    .illegal_instr(illegal_instr), .alu_timeout(alu_timeout), .jump_count(jump_count),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [31:0] model_rf [32];
  int          model_jc;
  logic [31:0] exp_q [$];
  logic [31:0] exp_rs1, exp_rs2, exp_res, exp_npc;
  logic        exp_jmp, exp_legal;
  logic [4:0]  exp_rd;

  // observations from the last instruction
  logic [31:0] obs_rs1, obs_rs2, obs_pcu, obs_ainstr, obs_apc;
  int          obs_av_cnt, obs_av_cycle, obs_pcv_cnt, obs_pcv_cycle;
  int          obs_ill_cnt, obs_to_cnt, obs_to_cycle;
  realtime     obs_accept_t;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    model_jc = 0;
  endtask

  task automatic model_decode(input logic [31:0] instr, input logic [31:0] pc);
    logic [31:0] a, b, imm;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    op = instr[6:0]; f7 = instr[31:25]; f3 = instr[14:12];
    a = model_rf[instr[19:15]];
    b = model_rf[instr[24:20]];
    exp_rs1 = a; exp_rs2 = b; exp_rd = instr[11:7];
    exp_jmp = 1'b0; exp_legal = 1'b1; exp_npc = pc + 32'd4; exp_res = 32'd0;
    if (op == 7'h6F) begin
      imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      exp_jmp = 1'b1; exp_res = pc + 32'd4; exp_npc = pc + imm;
    end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'b000) exp_res = a + b;
    else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'b000) exp_res = a - b;
    else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'b100) exp_res = a ^ b;
    else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'b110) exp_res = a | b;
    else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'b111) exp_res = a & b;
    else exp_legal = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic dbg_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    dbg_we = 1'b1; dbg_addr = addr; dbg_wdata = data;
    @(posedge clk); #1;
    dbg_we = 1'b0;
    if (addr != 5'd0) model_rf[addr] = data;
  endtask

  // Sends one instruction and acts as the ALU (answering delay cycles into WAIT).
  task automatic run(input logic [31:0] instr, input logic [31:0] pc, input int delay,
                     input logic respond, input logic dbg_acc, input logic dbg_wait,
                     input logic [4:0] daddr, input logic [31:0] ddata);
    int guard;
    obs_av_cnt = 0; obs_av_cycle = -1; obs_pcv_cnt = 0; obs_pcv_cycle = -1;
    obs_ill_cnt = 0; obs_to_cnt = 0; obs_to_cycle = -1;
    obs_rs1 = 32'hx; obs_rs2 = 32'hx; obs_pcu = 32'hx; obs_ainstr = 32'hx; obs_apc = 32'hx;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 40) begin @(negedge clk); guard++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_wait: in_ready=%b required 1", in_ready); end
    if (dbg_acc) begin
      dbg_we = 1'b1; dbg_addr = daddr; dbg_wdata = ddata;
      if (daddr != 5'd0) model_rf[daddr] = ddata;
    end
    model_decode(instr, pc);
    exp_q.push_back((exp_legal && respond) ? exp_npc : pc + 32'd4);
    in_valid = 1'b1; in_instruction = instr; in_pc = pc;
    @(posedge clk);
    obs_accept_t = $realtime;
    #1;
    in_valid = 1'b0; dbg_we = 1'b0;
    for (int c = 0; c < WB_TIMEOUT + 4; c++) begin
      if (respond && exp_legal && c == delay + 1) begin
        alu_result_valid = 1'b1; alu_result = exp_res; alu_next_pc = exp_npc; alu_is_jump = exp_jmp;
      end
      if (dbg_wait && c == 2) begin dbg_we = 1'b1; dbg_addr = daddr; dbg_wdata = ddata; end
      #1;
      if (alu_valid) begin
        obs_av_cnt++; obs_av_cycle = c; obs_rs1 = alu_rs1_data; obs_rs2 = alu_rs2_data;
        obs_ainstr = alu_instruction; obs_apc = alu_pc;
      end
      if (illegal_instr) obs_ill_cnt++;
      if (alu_timeout) begin obs_to_cnt++; obs_to_cycle = c; end
      if (pc_update_valid) begin obs_pcv_cnt++; obs_pcv_cycle = c; obs_pcu = pc_update; end
      @(posedge clk); #1;
      alu_result_valid = 1'b0; alu_is_jump = 1'b0; dbg_we = 1'b0;
      if (obs_pcv_cnt != 0) break;
    end
    if (exp_legal && respond) begin
      if (exp_rd != 5'd0) model_rf[exp_rd] = exp_res;
      if (exp_jmp) model_jc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    model_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    checks++; if (alu_valid !== 1'b0) begin errors++; $display("FAIL reset_alu_valid: got %b required 0", alu_valid); end
    checks++; if (pc_update_valid !== 1'b0) begin errors++; $display("FAIL reset_pcv: got %b required 0", pc_update_valid); end
    checks++; if (jump_count !== 16'd0) begin errors++; $display("FAIL reset_jump_count: got %h required 0", jump_count); end
    checks++; if (alu_instruction !== 32'd0) begin errors++; $display("FAIL reset_alu_instr: got %h required 0", alu_instruction); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL reset_reg x%0d: got %h required 0", i, dbg_rdata); end
    end
  endtask

  task automatic test_add();
    dbg_write(5'd1, 32'd15);
    dbg_write(5'd2, 32'd20);
    run(32'h00208133, 32'h0, 0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    void'(exp_q.pop_front());
    checks++; if (obs_av_cnt != 1 || obs_av_cycle != 0) begin errors++; $display("FAIL add_alu_valid: count %0d cycle %0d required 1 and 0", obs_av_cnt, obs_av_cycle); end
    checks++; if (obs_rs1 !== 32'd15) begin errors++; $display("FAIL add_rs1: got %h required %h", obs_rs1, 32'd15); end
    checks++; if (obs_rs2 !== 32'd20) begin errors++; $display("FAIL add_rs2: got %h required %h", obs_rs2, 32'd20); end
    checks++; if (obs_ainstr !== 32'h00208133) begin errors++; $display("FAIL add_alu_instr: got %h required 00208133", obs_ainstr); end
    checks++; if (obs_pcu !== 32'h4) begin errors++; $display("FAIL add_pc_update: got %h required 4", obs_pcu); end
    checks++; if (obs_pcv_cycle != 1) begin errors++; $display("FAIL add_latency: pc_update cycle %0d required 1", obs_pcv_cycle); end
    dbg_addr = 5'd2; #1;
    checks++; if (dbg_rdata !== 32'd35) begin errors++; $display("FAIL add_x2: got %h required %h", dbg_rdata, 32'd35); end
  endtask

  task automatic test_sub_xor();
    dbg_write(5'd1, 32'd10);
    dbg_write(5'd2, 32'd20);
    run(32'h402081B3, 32'h10, 1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    void'(exp_q.pop_front());
    dbg_addr = 5'd3; #1;
    checks++; if (dbg_rdata !== 32'hFFFFFFF6) begin errors++; $display("FAIL sub_x3: got %h required FFFFFFF6", dbg_rdata); end
    checks++; if (obs_pcu !== 32'h14) begin errors++; $display("FAIL sub_pc_update: got %h required 14", obs_pcu); end
    dbg_write(5'd1, 32'hFF);
    dbg_write(5'd2, 32'hAA);
    run(32'h0020C333, 32'h14, 0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    void'(exp_q.pop_front());
    dbg_addr = 5'd6; #1;
    checks++; if (dbg_rdata !== 32'h55) begin errors++; $display("FAIL xor_x6: got %h required 55", dbg_rdata); end
  endtask

  task automatic test_jal();
    run(32'h008000EF, 32'h30, 0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    void'(exp_q.pop_front());
    dbg_addr = 5'd1; #1;
    checks++; if (dbg_rdata !== 32'h34) begin errors++; $display("FAIL jal_x1: got %h required 34", dbg_rdata); end
    checks++; if (obs_pcu !== 32'h38) begin errors++; $display("FAIL jal_pc_update: got %h required 38", obs_pcu); end
    checks++; if (jump_count !== 16'd1) begin errors++; $display("FAIL jal_jump_count: got %0d required 1", jump_count); end
  endtask

  task automatic test_x0_illegal();
    run(32'h00208033, 32'h20, 2, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    void'(exp_q.pop_front());
    dbg_addr = 5'd0; #1;
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL x0_write: got %h required 0", dbg_rdata); end
    checks++; if (obs_pcu !== 32'h24 || obs_pcv_cycle != 3) begin errors++; $display("FAIL x0_pc_update: got %h at cycle %0d required 24 at 3", obs_pcu, obs_pcv_cycle); end
    dbg_write(5'd0, 32'h12345678);
    dbg_addr = 5'd0; #1;
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL x0_dbg_write: got %h required 0", dbg_rdata); end
    run(32'h00000013, 32'h40, 0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    void'(exp_q.pop_front());
    checks++; if (obs_ill_cnt != 1) begin errors++; $display("FAIL illegal_pulse: count %0d required 1", obs_ill_cnt); end
    checks++; if (obs_av_cnt != 0) begin errors++; $display("FAIL illegal_no_issue: alu_valid count %0d required 0", obs_av_cnt); end
    checks++; if (obs_pcu !== 32'h44) begin errors++; $display("FAIL illegal_pc_update: got %h required 44", obs_pcu); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      checks++; if (dbg_rdata !== model_rf[i]) begin errors++; $display("FAIL illegal_reg x%0d: got %h required %h", i, dbg_rdata, model_rf[i]); end
    end
    // sub-style funct7 with xor funct3 is not supported; pc+4 wraps
    run(32'h4020C0B3, 32'hFFFFFFFC, 0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    void'(exp_q.pop_front());
    checks++; if (obs_ill_cnt != 1) begin errors++; $display("FAIL illegal2_pulse: count %0d required 1", obs_ill_cnt); end
    checks++; if (obs_pcu !== 32'h0) begin errors++; $display("FAIL illegal2_pc_wrap: got %h required 0", obs_pcu); end
  endtask

  task automatic test_timeout();
    dbg_write(5'd5, 32'h1234);
    run(32'h002082B3, 32'h100, 0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
    void'(exp_q.pop_front());
    checks++; if (obs_to_cnt != 1 || obs_to_cycle != WB_TIMEOUT + 1) begin errors++; $display("FAIL timeout_pulse: count %0d cycle %0d required 1 at %0d", obs_to_cnt, obs_to_cycle, WB_TIMEOUT + 1); end
    checks++; if (obs_pcu !== 32'h104) begin errors++; $display("FAIL timeout_pc_update: got %h required 104", obs_pcu); end
    dbg_addr = 5'd5; #1;
    checks++; if (dbg_rdata !== 32'h1234) begin errors++; $display("FAIL timeout_no_write: got %h required 1234", dbg_rdata); end
    // last in-time answer just before expiry
    run(32'h002082B3, 32'h200, WB_TIMEOUT - 1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    checks++; if (obs_to_cnt != 0) begin errors++; $display("FAIL late_answer_timeout: count %0d required 0", obs_to_cnt); end
    checks++; if (obs_pcu !== exp_q[0]) begin errors++; $display("FAIL late_answer_pc: got %h required %h", obs_pcu, exp_q[0]); end
    void'(exp_q.pop_front());
    dbg_addr = 5'd5; #1;
    checks++; if (dbg_rdata !== model_rf[5]) begin errors++; $display("FAIL late_answer_x5: got %h required %h", dbg_rdata, model_rf[5]); end
  endtask

  task automatic test_back_to_back();
    realtime t0;
    dbg_write(5'd2, 32'd7);
    run(32'h002081B3, 32'h300, 0, 1'b1, 1'b1, 1'b0, 5'd1, 32'h100);
    void'(exp_q.pop_front());
    checks++; if (obs_rs1 !== 32'h100) begin errors++; $display("FAIL same_cycle_dbg_rs1: got %h required 100", obs_rs1); end
    dbg_addr = 5'd3; #1;
    checks++; if (dbg_rdata !== 32'h107) begin errors++; $display("FAIL same_cycle_dbg_x3: got %h required 107", dbg_rdata); end
    t0 = obs_accept_t;
    for (int k = 0; k < 3; k++) begin
      run(32'h003100B3, 32'h304 + 32'(4 * k), 0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      checks++; if (obs_accept_t - t0 != 30.0) begin errors++; $display("FAIL throughput %0d: accept spacing %0t required 30", k, obs_accept_t - t0); end
      checks++; if (obs_pcu !== exp_q[0]) begin errors++; $display("FAIL b2b_pc %0d: got %h required %h", k, obs_pcu, exp_q[0]); end
      void'(exp_q.pop_front());
      t0 = obs_accept_t;
    end
    dbg_addr = 5'd1; #1;
    checks++; if (dbg_rdata !== model_rf[1]) begin errors++; $display("FAIL b2b_x1: got %h required %h", dbg_rdata, model_rf[1]); end
  endtask

  task automatic test_stray_result();
    @(negedge clk);
    alu_result_valid = 1'b1; alu_result = 32'hCAFEF00D; alu_next_pc = 32'h999; alu_is_jump = 1'b1;
    #1;
    checks++; if (pc_update_valid !== 1'b0) begin errors++; $display("FAIL stray_pcv: got %b required 0", pc_update_valid); end
    @(posedge clk); #1;
    alu_result_valid = 1'b0; alu_is_jump = 1'b0;
    checks++; if (jump_count !== 16'(model_jc)) begin errors++; $display("FAIL stray_jump_count: got %0d required %0d", jump_count, model_jc); end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      checks++; if (dbg_rdata !== model_rf[i]) begin errors++; $display("FAIL stray_reg x%0d: got %h required %h", i, dbg_rdata, model_rf[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] instr, pc, r;
    logic [4:0]  rd, rs1, rs2;
    int          kind, delay;
    logic        dacc;
    exp_q.delete();
    for (int i = 1; i < 32; i++) dbg_write(5'(i), $urandom);
    for (int n = 0; n < 60; n++) begin
      rd = 5'($urandom_range(0, 31)); rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
      r = $urandom; pc = {r[31:2], 2'b00};
      kind = $urandom_range(0, 9);
      case (kind)
        0, 7: instr = {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
        1:    instr = {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
        2:    instr = {7'h00, rs2, rs1, 3'b111, rd, 7'h33};
        3:    instr = {7'h00, rs2, rs1, 3'b110, rd, 7'h33};
        4:    instr = {7'h00, rs2, rs1, 3'b100, rd, 7'h33};
        5:    instr = {r[31:12], rd, 7'h6F};
        6:    instr = {r[24:0], 7'h13};
        8:    instr = {7'h20, rs2, rs1, 3'(r[3:2] + 2'd1), rd, 7'h33};
        default: instr = {7'h01, rs2, rs1, 3'b000, rd, 7'h33};
      endcase
      delay = $urandom_range(0, 5);
      dacc = ($urandom_range(0, 3) == 0);
      run(instr, pc, delay, 1'b1, dacc, 1'b0, 5'($urandom_range(0, 31)), $urandom);
      checks++; if (obs_pcu !== exp_q[0]) begin errors++; $display("FAIL rnd_pc %0d: instr %h got %h required %h", n, instr, obs_pcu, exp_q[0]); end
      void'(exp_q.pop_front());
      checks++; if (obs_ill_cnt != (exp_legal ? 0 : 1)) begin errors++; $display("FAIL rnd_illegal %0d: instr %h count %0d required %0d", n, instr, obs_ill_cnt, exp_legal ? 0 : 1); end
      checks++; if (obs_pcv_cycle != (exp_legal ? delay + 1 : 0)) begin errors++; $display("FAIL rnd_latency %0d: cycle %0d required %0d", n, obs_pcv_cycle, exp_legal ? delay + 1 : 0); end
      if (exp_legal) begin
        checks++; if (obs_rs1 !== exp_rs1 || obs_rs2 !== exp_rs2) begin errors++; $display("FAIL rnd_operands %0d: got %h/%h required %h/%h", n, obs_rs1, obs_rs2, exp_rs1, exp_rs2); end
        checks++; if (obs_apc !== pc) begin errors++; $display("FAIL rnd_alu_pc %0d: got %h required %h", n, obs_apc, pc); end
      end
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      checks++; if (dbg_rdata !== model_rf[i]) begin errors++; $display("FAIL rnd_reg x%0d: got %h required %h", i, dbg_rdata, model_rf[i]); end
    end
    checks++; if (jump_count !== 16'(model_jc)) begin errors++; $display("FAIL rnd_jump_count: got %0d required %0d", jump_count, model_jc); end
  endtask

  task automatic test_reset_mid_wait();
    dbg_write(5'd7, 32'd5);
    @(negedge clk);
    in_valid = 1'b1; in_instruction = {7'h00, 5'd7, 5'd7, 3'b000, 5'd7, 7'h33}; in_pc = 32'h500;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    alu_result_valid = 1'b1; alu_result = 32'hAAAA; alu_next_pc = 32'h777; alu_is_jump = 1'b1;
    #1;
    checks++; if (pc_update_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_pcv: got %b required 0", pc_update_valid); end
    @(posedge clk); #1;
    resetn = 1'b1; alu_result_valid = 1'b0; alu_is_jump = 1'b0;
    model_reset();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_idle: in_ready %b required 1", in_ready); end
    checks++; if (jump_count !== 16'd0) begin errors++; $display("FAIL rst_wait_jump_count: got %0d required 0", jump_count); end
    dbg_addr = 5'd7; #1;
    checks++; if (dbg_rdata !== 32'd0) begin errors++; $display("FAIL rst_wait_x7: got %h required 0", dbg_rdata); end
    @(negedge clk); #1;
    checks++; if (pc_update_valid !== 1'b0 || alu_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_quiet: pcv %b alu_valid %b required 0 0", pc_update_valid, alu_valid); end
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_instruction = 32'd0; in_pc = 32'd0;
    alu_result = 32'd0; alu_next_pc = 32'd0; alu_result_valid = 1'b0; alu_is_jump = 1'b0;
    dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
    model_reset();
    test_reset();
    test_add();
    test_sub_xor();
    test_jal();
    test_x0_illegal();
    test_timeout();
    test_back_to_back();
    test_stray_result();
    test_random();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
